uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter feeding a UART transmitter
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN (abort WAIT_DONE after TIMEOUT_CYCLES without tx_done)
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [DATA_WIDTH-1:0] req_data1,
  output logic [1:0]            req_ready,
  output logic                  tx_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_grant;
  // Last requester whose frame finished; reset to 1 so requester 0 wins the first tie
  logic                  r_last_served;
  logic                  r_timeout_err;
  logic                  w_winner;
  logic                  w_accept;
  logic                  w_frame_end;
  logic                  w_timeout;

  // Single valid wins outright; on a tie the requester not served last wins
  always_comb begin
    w_winner = 1'b0;
    if (req_valid == 2'b11) begin
      w_winner = ~r_last_served;
    end else begin
      w_winner = req_valid[1];
    end
  end

  assign w_accept    = (r_state == S_IDLE) && (|req_valid);
  assign w_frame_end = (r_state == S_WAIT_DONE) && (tx_done || w_timeout);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_timeout_cnt;

  // Count WAIT_DONE cycles; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_WAIT_DONE)) begin
      r_timeout_cnt <= '0;
    end else begin
      r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT_DONE) && !tx_done &&
                     (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; tx_done only matters in WAIT_DONE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (tx_done || w_timeout) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; req_ready only in the IDLE accept cycle
  always_comb begin
    req_ready = 2'b00;
    tx_en     = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept && !rst) begin
          req_ready[w_winner] = 1'b1;
        end
      end
      S_START: begin
        tx_en = 1'b1;
      end
      default: begin
        tx_en = 1'b0;
      end
    endcase
  end

  // Latch byte and winner on accept; advance round-robin pointer when the frame ends
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data     <= '0;
      r_grant       <= 1'b0;
      r_last_served <= 1'b1;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tx_data <= w_winner ? req_data1 : req_data0;
        r_grant   <= w_winner;
      end
      if (w_frame_end) begin
        r_last_served <= r_grant;
      end
      r_timeout_err <= w_timeout;
    end
  end

  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       grant_id;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int served[$];

  uart_tx_arbiter #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference rule: lone valid wins; on a tie the one not served last wins, 0 if none served
  function automatic int model_winner(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (served.size() == 0) return 0;
    return 1 - served[served.size()-1];
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; tx_done = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    served.delete();
  endtask

  task automatic run_frame(input logic [1:0] v_acc, input logic [1:0] v_hold,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int delay, input bit spur);
    int         exp_g;
    logic [7:0] exp_d;
    exp_g = model_winner(v_acc);
    exp_d = (exp_g == 1) ? d1 : d0;
    req_valid = v_acc; req_data0 = d0; req_data1 = d1; tx_done = spur;
    #1;
    chk("accept_ready", req_ready, 32'(1 << exp_g));
    chk("accept_busy", busy, 0);
    chk("accept_tx_en", tx_en, 0);
    next_cycle();
    req_valid = v_hold; tx_done = spur;
    #1;
    chk("start_tx_en", tx_en, 1);
    chk("start_ready", req_ready, 0);
    chk("start_data", tx_data, exp_d);
    chk("start_grant", grant_id, exp_g);
    chk("start_busy", busy, 1);
    for (int k = 1; k < delay; k++) begin
      next_cycle();
      tx_done = 1'b0;
      req_data0 = 8'($urandom); req_data1 = 8'($urandom);
      #1;
      chk("wait_tx_en", tx_en, 0);
      chk("wait_ready", req_ready, 0);
      chk("wait_busy", busy, 1);
    end
    next_cycle();
    tx_done = 1'b1;
    #1;
    chk("done_busy", busy, 1);
    chk("done_data", tx_data, exp_d);
    next_cycle();
    tx_done = 1'b0; req_valid = 2'b00;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_tx_en", tx_en, 0);
    chk("idle_timeout", timeout_err, 0);
    chk("idle_data", tx_data, exp_d);
    chk("idle_grant", grant_id, exp_g);
    served.push_back(exp_g);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00; tx_done = 1'b0;
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);

    // Single requester 0, tx_done 20 cycles after tx_en
    run_frame(2'b01, 2'b00, 8'h55, 8'h99, 20, 1'b0);
    chk("single_data", tx_data, 8'h55);
    chk("single_grant", grant_id, 0);

    // Both valid from reset: 0xA1, 0xB2, 0xA1
    do_reset();
    run_frame(2'b11, 2'b11, 8'hA1, 8'hB2, 3, 1'b0);
    chk("rr0_data", tx_data, 8'hA1);
    chk("rr0_grant", grant_id, 0);
    run_frame(2'b11, 2'b11, 8'hA1, 8'hB2, 4, 1'b0);
    chk("rr1_data", tx_data, 8'hB2);
    chk("rr1_grant", grant_id, 1);
    run_frame(2'b11, 2'b11, 8'hA1, 8'hB2, 2, 1'b0);
    chk("rr2_data", tx_data, 8'hA1);
    chk("rr2_grant", grant_id, 0);

    // tx_done in IDLE is ignored, and in the accept/START cycles too
    tx_done = 1'b1;
    #1;
    chk("idle_done_busy", busy, 0);
    next_cycle();
    tx_done = 1'b0;
    #1;
    chk("idle_done_busy2", busy, 0);
    chk("idle_done_tx_en", tx_en, 0);
    run_frame(2'b10, 2'b00, 8'h11, 8'h22, 5, 1'b1);

    // Reset three cycles into WAIT_DONE; pointer would otherwise favour requester 0 then 1
    run_frame(2'b01, 2'b00, 8'h0F, 8'h00, 1, 1'b0);
    req_valid = 2'b10; req_data1 = 8'h3C;
    #1;
    chk("pre_rst_ready", req_ready, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_data", tx_data, 8'h3C);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    served.delete();
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_tx_en", tx_en, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_timeout", timeout_err, 0);
    run_frame(2'b11, 2'b00, 8'h77, 8'h88, 2, 1'b0);
    chk("post_rst_grant", grant_id, 0);

    // Randomized frames against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] v;
      logic [1:0] h;
      int         d;
      bit         s;
      if ($urandom_range(0, 3) == 0) begin
        tx_done = 1'b1;
        #1;
        chk("rand_idle_done", busy, 0);
        next_cycle();
        tx_done = 1'b0;
      end
      v = 2'($urandom_range(1, 3));
      h = v & 2'($urandom_range(0, 3));
      d = $urandom_range(1, 8);
      s = (d >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(v, h, 8'($urandom), 8'($urandom), d, s);
    end

    // No tx_done at all
    do_reset();
    req_valid = 2'b01; req_data0 = 8'h5A;
    #1;
    chk("to_accept", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      next_cycle();
      #1;
      chk("to_wait_busy", busy, 1);
      chk("to_wait_err", timeout_err, 0);
    end
    next_cycle();
    #1;
    chk("to_pulse", timeout_err, 1);
    chk("to_idle_busy", busy, 0);
    served.push_back(0);
    next_cycle();
    #1;
    chk("to_pulse_end", timeout_err, 0);
    run_frame(2'b11, 2'b00, 8'hC3, 8'hD4, 3, 1'b0);
    chk("to_next_grant", grant_id, 1);
`else
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      #1;
      chk("hang_busy", busy, 1);
      chk("hang_err", timeout_err, 0);
    end
    do_reset();
    #1;
    chk("hang_rst_busy", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
